// File: rtl/skinny_inv_sbox_pkg.sv
// rtl/skinny_inv_sbox_pkg.sv - shared types, widths and reference table for the masked inverse Skinny-64 S-box
package skinny_inv_sbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int STEP_W = 2;

  // Unmasked inverse S-box, only for checking; the datapath never indexes it.
  localparam logic [3:0] SKINNY_INV_SBOX [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };

  // Rotate a nibble right by one: (x3,x2,x1,x0) -> (x0,x3,x2,x1).
  function automatic logic [3:0] rotr1(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

endpackage

// File: rtl/dom_and_2sh.sv
// rtl/dom_and_2sh.sv - two-share domain-oriented masked AND, optional cross-term register stage
module dom_and_2sh #(
  parameter int DOM_REG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic r,
  output logic q0,
  output logic q1
);

  logic inner0, inner1, cross0, cross1;

  assign inner0 = a0 & b0;
  assign inner1 = a1 & b1;
  assign cross0 = (a0 & b1) ^ r;
  assign cross1 = (a1 & b0) ^ r;

  if (DOM_REG != 0) begin : g_reg
    logic cross0_q, cross1_q;

    // Capture the remasked cross terms so the two domains only meet through a register.
    always_ff @(posedge clk) begin
      if (rst) begin
        cross0_q <= 1'b0;
        cross1_q <= 1'b0;
      end else if (en) begin
        cross0_q <= cross0;
        cross1_q <= cross1;
      end
    end

    assign q0 = inner0 ^ cross0_q;
    assign q1 = inner1 ^ cross1_q;
  end else begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst ^ en;
    assign q0 = inner0 ^ cross0;
    assign q1 = inner1 ^ cross1;
  end

endmodule

// File: rtl/skinny_inv_sbox_serial_masked.sv
// rtl/skinny_inv_sbox_serial_masked.sv - serial two-share masked Skinny-64 inverse S-box (option SKINNY_INV_SBOX_OUT_REFRESH_EN)
module skinny_inv_sbox_serial_masked
  import skinny_inv_sbox_pkg::*;
#(
  parameter int DOM_REG = 1,
  parameter int N_STEPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [4:0] r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out0,
  output logic [3:0] out1
);

  if (N_STEPS != 4) begin : g_bad_n_steps
    $error("skinny_inv_sbox_serial_masked: N_STEPS must be 4");
  end

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_STEP = STEP;
  localparam logic [1:0] S_HOLD = HOLD;

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [3:0]        sh0_q, sh0_d, sh1_q, sh1_d;
  logic              phase_q, phase_d;
  logic [3:0]        rot0, rot1, nxt0, nxt1;
  logic              and_en, and_q0, and_q1, step_fire, last_step;

  // Step 0 works on the loaded nibble; later steps rotate first. Each share rotates on its own.
  assign rot0 = (cnt_q == '0) ? sh0_q : rotr1(sh0_q);
  assign rot1 = (cnt_q == '0) ? sh1_q : rotr1(sh1_q);

  // NOR(x3,x2) = ~x3 & ~x2; the complement lands on share 0 only.
  assign and_en = (state_q == S_STEP) && !phase_q;

  dom_and_2sh #(.DOM_REG(DOM_REG)) u_and (
    .clk (clk),
    .rst (rst),
    .en  (and_en),
    .a0  (~rot0[3]),
    .a1  (rot1[3]),
    .b0  (~rot0[2]),
    .b1  (rot1[2]),
    .r   (r[0]),
    .q0  (and_q0),
    .q1  (and_q1)
  );

  assign nxt0      = {rot0[3:1], rot0[0] ^ and_q0};
  assign nxt1      = {rot1[3:1], rot1[0] ^ and_q1};
  assign step_fire = (state_q == S_STEP) && ((DOM_REG == 0) || phase_q);
  assign last_step = (cnt_q == STEP_W'(N_STEPS - 1));

`ifndef SKINNY_INV_SBOX_OUT_REFRESH_EN
  logic unused_refresh_r;
  assign unused_refresh_r = ^r[4:1];
`endif

  // Next-state logic: load in IDLE, one step per fire in STEP, wait for the consumer in HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    phase_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh0_d   = in0;
          sh1_d   = in1;
          cnt_d   = '0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        phase_d = (DOM_REG != 0) && !phase_q;
        if (step_fire) begin
          sh0_d = nxt0;
          sh1_d = nxt1;
          cnt_d = cnt_q + 1'b1;
          if (last_step) begin
            state_d = S_HOLD;
`ifdef SKINNY_INV_SBOX_OUT_REFRESH_EN
            sh0_d = nxt0 ^ r[4:1];
            sh1_d = nxt1 ^ r[4:1];
`endif
          end
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and share registers; reset drops any nibble in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out0      = sh0_q;
  assign out1      = sh1_q;

endmodule

// File: tb/tb_skinny_inv_sbox_serial_masked.sv
// tb/tb_skinny_inv_sbox_serial_masked.sv - directed bench for both DOM_REG builds (option SKINNY_INV_SBOX_OUT_REFRESH_EN)
module tb_skinny_inv_sbox_serial_masked;
  import skinny_inv_sbox_pkg::*;

  localparam logic [3:0] EXP [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };
  localparam int LAT [2] = '{4, 8};

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_v [2];
  logic       in_ready_v [2];
  logic       out_valid_v [2];
  logic       out_ready_v [2];
  logic [3:0] in0_v [2];
  logic [3:0] in1_v [2];
  logic [3:0] out0_v [2];
  logic [3:0] out1_v [2];
  logic [4:0] r_v [2];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  skinny_inv_sbox_serial_masked #(.DOM_REG(0), .N_STEPS(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in0(in0_v[0]), .in1(in1_v[0]), .r(r_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out0(out0_v[0]), .out1(out1_v[0])
  );

  skinny_inv_sbox_serial_masked #(.DOM_REG(1), .N_STEPS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in0(in0_v[1]), .in1(in1_v[1]), .r(r_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out0(out0_v[1]), .out1(out1_v[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b0;
      in0_v[d] = '0; in1_v[d] = '0; r_v[d] = '0;
    end
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Present one nibble from IDLE, count edges from acceptance to out_valid.
  task automatic run_nibble(input int d, input logic [3:0] x, input logic [3:0] m,
                            input logic [4:0] rv, input bit rand_r, input bit release_out,
                            output logic [3:0] o0, output logic [3:0] o1, output int lat);
    in0_v[d] = x ^ m; in1_v[d] = m; r_v[d] = rv;
    out_ready_v[d] = 1'b0; in_valid_v[d] = 1'b1;
    tick;
    in_valid_v[d] = 1'b0;
    lat = 0;
    while (out_valid_v[d] !== 1'b1 && lat < 40) begin
      if (rand_r) r_v[d] = 5'($urandom_range(0, 31));
      tick;
      lat++;
    end
    o0 = out0_v[d];
    o1 = out1_v[d];
    if (release_out) begin
      out_ready_v[d] = 1'b1;
      tick;
      out_ready_v[d] = 1'b0;
    end
  endtask

  task automatic test_reset(input int d);
    n_tests++;
    if (in_ready_v[d] !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready d=%0d got %b expected 1", d, in_ready_v[d]); end
    n_tests++;
    if (out_valid_v[d] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid d=%0d got %b expected 0", d, out_valid_v[d]); end
    n_tests++;
    if (out0_v[d] !== 4'h0 || out1_v[d] !== 4'h0) begin
      n_fail++; $display("FAIL reset_outs d=%0d got %h/%h expected 0/0", d, out0_v[d], out1_v[d]);
    end
  endtask

  task automatic test_exhaustive(input int d);
    logic [3:0] o0, o1;
    int lat;
    for (int x = 0; x < 16; x++) begin
      run_nibble(d, 4'(x), 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'b1, 1'b1, o0, o1, lat);
      n_tests++;
      if ((o0 ^ o1) !== EXP[x]) begin
        n_fail++; $display("FAIL exhaustive_value d=%0d x=%h got %h expected %h", d, x, o0 ^ o1, EXP[x]);
      end
      n_tests++;
      if (lat != LAT[d]) begin
        n_fail++; $display("FAIL exhaustive_latency d=%0d x=%h got %0d expected %0d", d, x, lat, LAT[d]);
      end
    end
  endtask

  task automatic test_backpressure(input int d);
    logic [3:0] o0, o1;
    int lat;
    run_nibble(d, 4'h7, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'b1, 1'b0, o0, o1, lat);
    n_tests++;
    if ((o0 ^ o1) !== 4'hE || lat != LAT[d]) begin
      n_fail++; $display("FAIL backpressure_value d=%0d got %h lat %0d expected E lat %0d", d, o0 ^ o1, lat, LAT[d]);
    end
    for (int c = 0; c < 10; c++) begin
      r_v[d] = 5'($urandom_range(0, 31));
      tick;
      n_tests++;
      if (out0_v[d] !== o0 || out1_v[d] !== o1 || out_valid_v[d] !== 1'b1 || in_ready_v[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold d=%0d c=%0d got %h/%h v=%b rdy=%b expected %h/%h v=1 rdy=0",
                 d, c, out0_v[d], out1_v[d], out_valid_v[d], in_ready_v[d], o0, o1);
      end
    end
    out_ready_v[d] = 1'b1;
    tick;
    out_ready_v[d] = 1'b0;
    n_tests++;
    if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release d=%0d got rdy=%b v=%b expected rdy=1 v=0", d, in_ready_v[d], out_valid_v[d]);
    end
  endtask

  task automatic test_reset_mid(input int d);
    logic [3:0] o0, o1;
    int lat;
    in1_v[d] = 4'h5; in0_v[d] = 4'h9 ^ 4'h5; r_v[d] = 5'h13; in_valid_v[d] = 1'b1;
    tick;
    in_valid_v[d] = 1'b0;
    for (int c = 0; c < 2 * (d + 1); c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if (in_ready_v[d] !== 1'b1 || out_valid_v[d] !== 1'b0 || out0_v[d] !== 4'h0 || out1_v[d] !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_mid d=%0d got rdy=%b v=%b out=%h/%h expected rdy=1 v=0 out=0/0",
               d, in_ready_v[d], out_valid_v[d], out0_v[d], out1_v[d]);
    end
    run_nibble(d, 4'h2, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'b1, 1'b1, o0, o1, lat);
    n_tests++;
    if ((o0 ^ o1) !== 4'h6 || lat != LAT[d]) begin
      n_fail++; $display("FAIL reset_mid_after d=%0d got %h lat %0d expected 6 lat %0d", d, o0 ^ o1, lat, LAT[d]);
    end
  endtask

  task automatic test_back_to_back(input int d);
    int prev = -1;
    int nacc = 0;
    int bad  = 0;
    int exp_acc;
    exp_acc = (59 / (LAT[d] + 2)) + 1;
    in1_v[d] = 4'hB; in0_v[d] = 4'h4 ^ 4'hB;
    in_valid_v[d] = 1'b1; out_ready_v[d] = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      r_v[d] = 5'($urandom_range(0, 31));
      if (in_ready_v[d] === 1'b1) begin
        if (prev >= 0 && cyc - prev != LAT[d] + 2) bad++;
        prev = cyc;
        nacc++;
      end
      if (in_ready_v[d] === 1'b1 && out_valid_v[d] === 1'b1) bad++;
      if (out_valid_v[d] === 1'b1 && (out0_v[d] ^ out1_v[d]) !== 4'hC) bad++;
      tick;
    end
    in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b0;
    n_tests++;
    if (bad != 0 || nacc != exp_acc) begin
      n_fail++; $display("FAIL back_to_back d=%0d got accepts=%0d bad=%0d expected accepts=%0d bad=0", d, nacc, bad, exp_acc);
    end
    do_reset;
  endtask

  task automatic test_mask_indep(input int d);
    int hist [16];
    int bad = 0;
    real chi2 = 0.0;
    logic [3:0] o0, o1;
    int lat;
    for (int i = 0; i < 16; i++) hist[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      run_nibble(d, 4'h5, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 1'b1, 1'b1, o0, o1, lat);
      if ((o0 ^ o1) !== SKINNY_INV_SBOX[5] || lat != LAT[d]) bad++;
      hist[o0]++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mask_recombine d=%0d got %0d bad runs expected 0", d, bad);
    end
    for (int i = 0; i < 16; i++) chi2 += ((hist[i] - 62.5) * (hist[i] - 62.5)) / 62.5;
    n_tests++;
    if (!(chi2 < 44.0)) begin
      n_fail++; $display("FAIL mask_uniform d=%0d got chi2=%0f expected below 44", d, chi2);
    end
  endtask

`ifdef SKINNY_INV_SBOX_OUT_REFRESH_EN
  task automatic test_refresh(input int d);
    logic [3:0] b0, b1, o0, o1;
    logic [3:0] masks [4];
    int lat;
    masks[0] = 4'h1; masks[1] = 4'h5; masks[2] = 4'hA; masks[3] = 4'hF;
    run_nibble(d, 4'h3, 4'h6, 5'b0000_1, 1'b0, 1'b1, b0, b1, lat);
    n_tests++;
    if ((b0 ^ b1) !== 4'h8 || lat != LAT[d]) begin
      n_fail++; $display("FAIL refresh_base d=%0d got %h lat %0d expected 8 lat %0d", d, b0 ^ b1, lat, LAT[d]);
    end
    for (int k = 0; k < 4; k++) begin
      run_nibble(d, 4'h3, 4'h6, {masks[k], 1'b1}, 1'b0, 1'b1, o0, o1, lat);
      n_tests++;
      if (o0 !== (b0 ^ masks[k]) || (o0 ^ o1) !== (b0 ^ b1) || lat != LAT[d]) begin
        n_fail++;
        $display("FAIL refresh_mask d=%0d m=%h got out0=%h x=%h lat %0d expected out0=%h x=%h lat %0d",
                 d, masks[k], o0, o0 ^ o1, lat, b0 ^ masks[k], b0 ^ b1, LAT[d]);
      end
    end
  endtask
`endif

  initial begin
    do_reset;
    for (int d = 0; d < 2; d++) test_reset(d);
    for (int d = 0; d < 2; d++) begin
      test_exhaustive(d);
      test_backpressure(d);
      test_reset_mid(d);
      test_back_to_back(d);
      test_mask_indep(d);
`ifdef SKINNY_INV_SBOX_OUT_REFRESH_EN
      test_refresh(d);
`endif
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
